// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared widths, ALU operation codes, FSM states and helpers for the
// MEM-stage load/store unit (mem_lsu, mem_lane_align, mem_lsu_if).
// Optional feature macro used by the unit: MEM_LLSC_EN (LL/SC link bit).
package mem_lsu_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 8;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned CNT_W      = 8;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP   = 8'b1110_1011;
  localparam logic [ALUOP_W-1:0] EXE_LL_OP   = 8'b1111_0000;
  localparam logic [ALUOP_W-1:0] EXE_SC_OP   = 8'b1111_1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Request held on the data bus for the whole REQ phase
  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] addr;
    logic [SEL_W-1:0] sel;
    logic [REG_W-1:0] wdata;
  } dbus_cmd_t;

  function automatic logic is_load(input logic [ALUOP_W-1:0] op);
    is_load = (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
              (op == EXE_LHU_OP) || (op == EXE_LW_OP) || (op == EXE_LL_OP);
  endfunction

  function automatic logic is_store(input logic [ALUOP_W-1:0] op);
    is_store = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP) ||
               (op == EXE_SC_OP);
  endfunction

  function automatic logic is_aligned(input logic [ALUOP_W-1:0] op, input logic [1:0] a);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:           is_aligned = (a[0] == 1'b0);
      EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP: is_aligned = (a == 2'b00);
      default:                                    is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: req/ack data bus between the load/store unit (master) and memory (slave).
//   dbus_req/we/addr/sel/wdata : master -> slave, held stable while dbus_req is high
//   dbus_rdata/dbus_ack        : slave -> master, rdata valid with the 1-cycle ack pulse
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic             dbus_req;
  logic             dbus_we;
  logic [REG_W-1:0] dbus_addr;
  logic [SEL_W-1:0] dbus_sel;
  logic [REG_W-1:0] dbus_wdata;
  logic [REG_W-1:0] dbus_rdata;
  logic             dbus_ack;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_rdata, dbus_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane steering for loads and stores (combinational).
//   addr_lo_i   : effective address bits [1:0]
//   aluop_i     : load/store subtype
//   reg2_i      : store data (rt)
//   rdata_i     : raw bus read data
//   sel_o       : byte-lane enables
//   wdata_o     : store data replicated across lanes
//   rdata_ext_o : selected lane(s), sign- or zero-extended
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]         addr_lo_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [REG_W-1:0]   reg2_i,
  input  logic [REG_W-1:0]   rdata_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic [REG_W-1:0]   wdata_o,
  output logic [REG_W-1:0]   rdata_ext_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Address 0 is the most significant lane
  always_comb begin
    lane_b = 8'h00;
    case (addr_lo_i)
      2'b00:   lane_b = rdata_i[31:24];
      2'b01:   lane_b = rdata_i[23:16];
      2'b10:   lane_b = rdata_i[15:8];
      default: lane_b = rdata_i[7:0];
    endcase
    lane_h = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    sel_o       = '0;
    wdata_o     = reg2_i;
    rdata_ext_o = rdata_i;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        sel_o       = SEL_W'(4'b1000 >> addr_lo_i);
        wdata_o     = {4{reg2_i[7:0]}};
        rdata_ext_o = (aluop_i == EXE_LB_OP) ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        sel_o       = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o     = {2{reg2_i[15:0]}};
        rdata_ext_o = (aluop_i == EXE_LH_OP) ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      end
      EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP: begin
        sel_o = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Runs byte/half/word accesses on a req/ack bus,
// stalls the pipeline while an access is outstanding, and drives the MEM/WB inputs.
// Non-memory instructions pass straight through. Reset is synchronous, active-high.
//   clk, rst            : clock, synchronous reset
//   mem_*               : EX/MEM register outputs (wd, wreg, wdata, hi, lo, whilo, aluop, mem_addr, reg2)
//   wb_*                : MEM/WB register inputs
//   stallreq_mem        : pipeline freeze request (combinational)
//   exc_adel/ades/buserr: 1-cycle exception pulses
//   llbit_clr           : link-bit clear (only with MEM_LLSC_EN)
//   dbus                : data bus master port
// Build option: define MEM_LLSC_EN for LL/SC link-bit tracking; otherwise LL acts as LW
// and SC as SW that always reports success.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [REG_W-1:0]      mem_wdata,
  input  logic [REG_W-1:0]      mem_hi,
  input  logic [REG_W-1:0]      mem_lo,
  input  logic                  mem_whilo,
  input  logic [ALUOP_W-1:0]    mem_aluop,
  input  logic [REG_W-1:0]      mem_mem_addr,
  input  logic [REG_W-1:0]      mem_reg2,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [REG_W-1:0]      wb_wdata,
  output logic [REG_W-1:0]      wb_hi,
  output logic [REG_W-1:0]      wb_lo,
  output logic                  wb_whilo,
  output logic                  stallreq_mem,
  output logic                  exc_adel,
  output logic                  exc_ades,
  output logic                  exc_buserr,
`ifdef MEM_LLSC_EN
  input  logic                  llbit_clr,
`endif
  mem_lsu_if.master             dbus
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dbus_cmd_t        cmd_q, cmd_d;
  logic [REG_W-1:0] rdata_q, rdata_d;
  logic             buserr_q, buserr_d;

  logic             op_load, op_store, op_sc, op_aligned, sc_fail;
  logic [SEL_W-1:0] lane_sel;
  logic [REG_W-1:0] lane_wdata, lane_rdata;

`ifdef MEM_LLSC_EN
  logic llbit_q, llbit_d;
  assign sc_fail = op_sc & ~llbit_q;
`else
  assign sc_fail = 1'b0;
`endif

  assign op_load    = is_load(mem_aluop);
  assign op_store   = is_store(mem_aluop);
  assign op_sc      = (mem_aluop == EXE_SC_OP);
  assign op_aligned = is_aligned(mem_aluop, mem_mem_addr[1:0]);

  mem_lane_align u_lane_align (
    .addr_lo_i   (mem_mem_addr[1:0]),
    .aluop_i     (mem_aluop),
    .reg2_i      (mem_reg2),
    .rdata_i     (dbus.dbus_rdata),
    .sel_o       (lane_sel),
    .wdata_o     (lane_wdata),
    .rdata_ext_o (lane_rdata)
  );

  // Bus request comes from registers so it stays stable for the whole REQ phase
  assign dbus.dbus_req   = (state_q == ST_REQ);
  assign dbus.dbus_we    = cmd_q.we;
  assign dbus.dbus_addr  = cmd_q.addr;
  assign dbus.dbus_sel   = cmd_q.sel;
  assign dbus.dbus_wdata = cmd_q.wdata;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

`ifdef MEM_LLSC_EN
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) llbit_q <= 1'b0;
    else                   llbit_q <= llbit_d;
  end
`endif

  // Next state, bus command and MEM/WB outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    cmd_d        = cmd_q;
    rdata_d      = rdata_q;
    buserr_d     = 1'b0;
    wb_wd        = mem_wd;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;
    wb_hi        = mem_hi;
    wb_lo        = mem_lo;
    wb_whilo     = mem_whilo;
    stallreq_mem = NO_STOP;
    exc_adel     = 1'b0;
    exc_ades     = 1'b0;
    exc_buserr   = 1'b0;
`ifdef MEM_LLSC_EN
    llbit_d      = llbit_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cmd_d = '0;
        if (op_load || op_store) begin
          if (!op_aligned) begin
            exc_adel = op_load;
            exc_ades = op_store;
            wb_wreg  = 1'b0;
          end else if (sc_fail) begin
            // Lost reservation: report failure without touching the bus
            wb_wdata = '0;
            wb_wreg  = 1'b1;
          end else begin
            stallreq_mem = STOP;
            wb_wreg      = 1'b0;
            wb_whilo     = 1'b0;
            cmd_d.we     = op_store;
            cmd_d.addr   = {mem_mem_addr[REG_W-1:2], 2'b00};
            cmd_d.sel    = lane_sel;
            cmd_d.wdata  = lane_wdata;
            state_d      = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        stallreq_mem = STOP;
        wb_wreg      = 1'b0;
        wb_whilo     = 1'b0;
        cnt_d        = cnt_q + CNT_W'(1);
        if (dbus.dbus_ack) begin
          rdata_d = lane_rdata;
          cnt_d   = '0;
          cmd_d   = '0;
          state_d = ST_DONE;
`ifdef MEM_LLSC_EN
          if (mem_aluop == EXE_LL_OP) llbit_d = 1'b1;
          if (op_sc)                  llbit_d = 1'b0;
`endif
        end else if (cnt_d == CNT_W'(ACK_TIMEOUT)) begin
          buserr_d = 1'b1;
          cnt_d    = '0;
          cmd_d    = '0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        // EX/MEM still holds the same instruction, so decode it again for writeback
        exc_buserr = buserr_q;
        state_d    = ST_IDLE;
        cmd_d      = '0;
        if (op_load) begin
          wb_wdata = rdata_q;
          wb_wreg  = mem_wreg & ~buserr_q;
        end else begin
          wb_wdata = op_sc ? REG_W'(1) : mem_wdata;
          wb_wreg  = op_sc & mem_wreg & ~buserr_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef MEM_LLSC_EN
    if (llbit_clr) llbit_d = 1'b0;
`endif

    if (rst == RST_ENABLE) begin
      wb_wd        = '0;
      wb_wreg      = 1'b0;
      wb_wdata     = '0;
      wb_hi        = '0;
      wb_lo        = '0;
      wb_whilo     = 1'b0;
      stallreq_mem = NO_STOP;
      exc_adel     = 1'b0;
      exc_ades     = 1'b0;
      exc_buserr   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu (ACK_TIMEOUT = 4). Inputs change on the falling
// edge and outputs are sampled 1 time unit later. Define MEM_LLSC_EN to include LL/SC tests.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic        wb_whilo;
  logic        stallreq_mem, exc_adel, exc_ades, exc_buserr;
`ifdef MEM_LLSC_EN
  logic        llbit_clr;
`endif

  int errors = 0;
  int checks = 0;

  mem_lsu_if bus();

  mem_lsu #(.ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_whilo    (mem_whilo),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .wb_hi        (wb_hi),
    .wb_lo        (wb_lo),
    .wb_whilo     (wb_whilo),
    .stallreq_mem (stallreq_mem),
    .exc_adel     (exc_adel),
    .exc_ades     (exc_ades),
    .exc_buserr   (exc_buserr),
`ifdef MEM_LLSC_EN
    .llbit_clr    (llbit_clr),
`endif
    .dbus         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] wdata, input logic [4:0] wd, input logic wreg);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wdata    = wdata;
    mem_wd       = wd;
    mem_wreg     = wreg;
    mem_hi       = 32'h0;
    mem_lo       = 32'h0;
    mem_whilo    = 1'b0;
  endtask

  task automatic test_reset();
    logic [102:0] wb_all;
    logic [3:0]   ctl_all;
    logic [69:0]  bus_all;
    rst = 1'b1;
    bus.dbus_ack = 1'b0;
    bus.dbus_rdata = 32'h0;
    drive(EXE_ADDU_OP, 32'h10, 32'h20, 32'h5, 5'd3, 1'b1);
    mem_hi = 32'hAA; mem_lo = 32'hBB; mem_whilo = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    wb_all  = {wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo};
    ctl_all = {stallreq_mem, exc_adel, exc_ades, exc_buserr};
    bus_all = {bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_sel, bus.dbus_wdata};
    checks++; if (wb_all !== '0) begin errors++; $display("FAIL reset_wb: got %h expected 0", wb_all); end
    checks++; if (ctl_all !== '0) begin errors++; $display("FAIL reset_ctl: got %b expected 0000", ctl_all); end
    checks++; if (bus_all !== '0) begin errors++; $display("FAIL reset_bus: got %h expected 0", bus_all); end
  endtask

  task automatic test_passthru();
    @(negedge clk);
    rst = 1'b0;
    drive(EXE_ADDU_OP, 32'h10, 32'h20, 32'h5, 5'd3, 1'b1);
    mem_hi = 32'hAA; mem_lo = 32'hBB; mem_whilo = 1'b1;
    #1;
    checks++; if ({wb_wd, wb_wreg, wb_wdata} !== {5'd3, 1'b1, 32'h5}) begin errors++;
      $display("FAIL pass_wb: got %h/%b/%h expected 03/1/00000005", wb_wd, wb_wreg, wb_wdata); end
    checks++; if ({wb_hi, wb_lo, wb_whilo} !== {32'hAA, 32'hBB, 1'b1}) begin errors++;
      $display("FAIL pass_hilo: got %h/%h/%b expected aa/bb/1", wb_hi, wb_lo, wb_whilo); end
    checks++; if ({stallreq_mem, bus.dbus_req} !== 2'b00) begin errors++;
      $display("FAIL pass_stall: got stall=%b req=%b expected 0 0", stallreq_mem, bus.dbus_req); end
    // Stray ack while idle must be ignored
    @(negedge clk); bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hFFFF_FFFF; #1;
    @(negedge clk); bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'h0; #1;
    checks++; if ({stallreq_mem, bus.dbus_req, wb_wdata} !== {2'b00, 32'h5}) begin errors++;
      $display("FAIL stray_ack: got stall=%b req=%b wdata=%h expected 0 0 00000005",
               stallreq_mem, bus.dbus_req, wb_wdata); end
  endtask

  task automatic run_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                          input int wait_n, input logic [3:0] exp_sel, input logic [31:0] exp_data,
                          input string tag);
    int stall_cyc = 0;
    @(negedge clk); drive(op, addr, 32'h0, addr, 5'd9, 1'b1); #1;
    stall_cyc += int'(stallreq_mem);
    checks++; if ({stallreq_mem, bus.dbus_req, wb_wreg} !== 3'b100) begin errors++;
      $display("FAIL %s_issue: got stall=%b req=%b wreg=%b expected 1 0 0", tag, stallreq_mem, bus.dbus_req, wb_wreg); end
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk); #1;
      stall_cyc += int'(stallreq_mem);
    end
    @(negedge clk); bus.dbus_ack = 1'b1; bus.dbus_rdata = rdata; #1;
    stall_cyc += int'(stallreq_mem);
    checks++; if ({bus.dbus_req, bus.dbus_we, bus.dbus_sel, bus.dbus_addr} !== {2'b10, exp_sel, addr[31:2], 2'b00}) begin errors++;
      $display("FAIL %s_bus: got req=%b we=%b sel=%b addr=%h expected 1 0 %b %h", tag, bus.dbus_req, bus.dbus_we,
               bus.dbus_sel, bus.dbus_addr, exp_sel, {addr[31:2], 2'b00}); end
    @(negedge clk); bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'h0; #1;
    stall_cyc += int'(stallreq_mem);
    checks++; if ({stallreq_mem, bus.dbus_req, wb_wreg, wb_wd, wb_wdata} !== {3'b001, 5'd9, exp_data}) begin errors++;
      $display("FAIL %s_done: got stall=%b req=%b wreg=%b wd=%0d wdata=%h expected 0 0 1 9 %h", tag, stallreq_mem,
               bus.dbus_req, wb_wreg, wb_wd, wb_wdata, exp_data); end
    checks++; if (stall_cyc !== wait_n + 2) begin errors++;
      $display("FAIL %s_stall_len: got %0d expected %0d", tag, stall_cyc, wait_n + 2); end
  endtask

  task automatic run_store(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [3:0] exp_sel, input logic [31:0] exp_wdata, input logic exp_wreg,
                           input logic [31:0] exp_wb, input string tag);
    @(negedge clk); drive(op, addr, reg2, 32'h77, 5'd4, 1'b1); #1;
    checks++; if ({stallreq_mem, bus.dbus_req} !== 2'b10) begin errors++;
      $display("FAIL %s_issue: got stall=%b req=%b expected 1 0", tag, stallreq_mem, bus.dbus_req); end
    @(negedge clk); bus.dbus_ack = 1'b1; #1;
    checks++; if ({bus.dbus_req, bus.dbus_we, bus.dbus_sel, bus.dbus_wdata, bus.dbus_addr} !==
                  {2'b11, exp_sel, exp_wdata, addr[31:2], 2'b00}) begin errors++;
      $display("FAIL %s_bus: got req=%b we=%b sel=%b wdata=%h addr=%h expected 1 1 %b %h %h", tag, bus.dbus_req,
               bus.dbus_we, bus.dbus_sel, bus.dbus_wdata, bus.dbus_addr, exp_sel, exp_wdata, {addr[31:2], 2'b00}); end
    @(negedge clk); bus.dbus_ack = 1'b0; #1;
    checks++; if ({stallreq_mem, bus.dbus_req, wb_wreg, wb_wdata} !== {2'b00, exp_wreg, exp_wb}) begin errors++;
      $display("FAIL %s_done: got stall=%b req=%b wreg=%b wdata=%h expected 0 0 %b %h", tag, stallreq_mem,
               bus.dbus_req, wb_wreg, wb_wdata, exp_wreg, exp_wb); end
  endtask

  task automatic test_loads();
    run_load(EXE_LB_OP,  32'h0000_1003, 32'h0000_00F0, 1, 4'b0001, 32'hFFFF_FFF0, "lb");
    run_load(EXE_LBU_OP, 32'h0000_1001, 32'h0080_0000, 0, 4'b0100, 32'h0000_0080, "lbu");
    run_load(EXE_LH_OP,  32'h0000_2000, 32'h8765_1234, 2, 4'b1100, 32'hFFFF_8765, "lh");
    run_load(EXE_LHU_OP, 32'h0000_2002, 32'h1234_8765, 0, 4'b0011, 32'h0000_8765, "lhu");
    run_load(EXE_LW_OP,  32'h0000_3004, 32'hCAFE_BABE, 0, 4'b1111, 32'hCAFE_BABE, "lw");
  endtask

  task automatic test_stores();
    run_store(EXE_SH_OP, 32'h0000_2002, 32'h1234_ABCD, 4'b0011, 32'hABCD_ABCD, 1'b0, 32'h77, "sh");
    run_store(EXE_SB_OP, 32'h0000_2001, 32'h0000_00EF, 4'b0100, 32'hEFEF_EFEF, 1'b0, 32'h77, "sb");
    run_store(EXE_SW_OP, 32'h0000_2008, 32'h0102_0304, 4'b1111, 32'h0102_0304, 1'b0, 32'h77, "sw");
  endtask

  task automatic test_misaligned();
    @(negedge clk); drive(EXE_LW_OP, 32'h0000_2001, 32'h0, 32'h2001, 5'd5, 1'b1); #1;
    checks++; if ({exc_adel, exc_ades, stallreq_mem, bus.dbus_req, wb_wreg} !== 5'b10000) begin errors++;
      $display("FAIL adel: got adel=%b ades=%b stall=%b req=%b wreg=%b expected 1 0 0 0 0",
               exc_adel, exc_ades, stallreq_mem, bus.dbus_req, wb_wreg); end
    @(negedge clk); drive(EXE_SH_OP, 32'h0000_2003, 32'h5555, 32'h2003, 5'd5, 1'b1); #1;
    checks++; if ({exc_adel, exc_ades, stallreq_mem, bus.dbus_req, wb_wreg} !== 5'b01000) begin errors++;
      $display("FAIL ades: got adel=%b ades=%b stall=%b req=%b wreg=%b expected 0 1 0 0 0",
               exc_adel, exc_ades, stallreq_mem, bus.dbus_req, wb_wreg); end
    @(negedge clk); drive(EXE_ADDU_OP, 32'h0, 32'h0, 32'h5, 5'd3, 1'b1); #1;
    checks++; if ({exc_adel, exc_ades, bus.dbus_req} !== 3'b000) begin errors++;
      $display("FAIL exc_pulse: got adel=%b ades=%b req=%b expected 0 0 0", exc_adel, exc_ades, bus.dbus_req); end
  endtask

  task automatic test_timeout();
    int req_cyc = 0;
    @(negedge clk); drive(EXE_LW_OP, 32'h0000_3000, 32'h0, 32'h3000, 5'd6, 1'b1); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      req_cyc += int'(bus.dbus_req);
      checks++; if ({stallreq_mem, exc_buserr} !== 2'b10) begin errors++;
        $display("FAIL to_wait%0d: got stall=%b buserr=%b expected 1 0", i, stallreq_mem, exc_buserr); end
    end
    @(negedge clk); #1;
    checks++; if ({bus.dbus_req, stallreq_mem, exc_buserr, wb_wreg} !== 4'b0010) begin errors++;
      $display("FAIL to_done: got req=%b stall=%b buserr=%b wreg=%b expected 0 0 1 0",
               bus.dbus_req, stallreq_mem, exc_buserr, wb_wreg); end
    checks++; if (req_cyc !== 4) begin errors++;
      $display("FAIL to_req_len: got %0d expected 4", req_cyc); end
    @(negedge clk); drive(EXE_ADDU_OP, 32'h0, 32'h0, 32'h5, 5'd3, 1'b1); #1;
    checks++; if ({exc_buserr, bus.dbus_req, wb_wdata} !== {2'b00, 32'h5}) begin errors++;
      $display("FAIL to_after: got buserr=%b req=%b wdata=%h expected 0 0 00000005", exc_buserr, bus.dbus_req, wb_wdata); end
  endtask

  task automatic test_reset_in_req();
    @(negedge clk); drive(EXE_LW_OP, 32'h0000_4000, 32'h0, 32'h4000, 5'd2, 1'b1); #1;
    @(negedge clk); #1;
    checks++; if (bus.dbus_req !== 1'b1) begin errors++;
      $display("FAIL rreq_pre: got req=%b expected 1", bus.dbus_req); end
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); #1;
    checks++; if ({bus.dbus_req, bus.dbus_we, bus.dbus_sel, bus.dbus_addr, stallreq_mem, wb_wreg, wb_wdata, wb_wd} !== '0) begin errors++;
      $display("FAIL rreq_post: got req=%b sel=%b addr=%h stall=%b wreg=%b wdata=%h expected all 0",
               bus.dbus_req, bus.dbus_sel, bus.dbus_addr, stallreq_mem, wb_wreg, wb_wdata); end
    @(negedge clk); rst = 1'b0; drive(EXE_ADDU_OP, 32'h0, 32'h0, 32'h5, 5'd3, 1'b1); #1;
    checks++; if ({bus.dbus_req, stallreq_mem, wb_wdata} !== {2'b00, 32'h5}) begin errors++;
      $display("FAIL rreq_recover: got req=%b stall=%b wdata=%h expected 0 0 00000005", bus.dbus_req, stallreq_mem, wb_wdata); end
  endtask

`ifdef MEM_LLSC_EN
  task automatic test_llsc();
    run_load(EXE_LL_OP, 32'h0000_0100, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344, "ll1");
    run_store(EXE_SC_OP, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h1, "sc_ok");
    // Successful SC consumed the link: a second SC fails
    @(negedge clk); drive(EXE_SC_OP, 32'h0000_0100, 32'hDEAD_BEEF, 32'h77, 5'd4, 1'b1); #1;
    checks++; if ({stallreq_mem, bus.dbus_req, wb_wreg, wb_wdata} !== {3'b001, 32'h0}) begin errors++;
      $display("FAIL sc_again: got stall=%b req=%b wreg=%b wdata=%h expected 0 0 1 0", stallreq_mem, bus.dbus_req, wb_wreg, wb_wdata); end
    run_load(EXE_LL_OP, 32'h0000_0100, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344, "ll2");
    @(negedge clk); drive(EXE_ADDU_OP, 32'h0, 32'h0, 32'h5, 5'd3, 1'b1); llbit_clr = 1'b1; #1;
    @(negedge clk); llbit_clr = 1'b0; drive(EXE_SC_OP, 32'h0000_0100, 32'hDEAD_BEEF, 32'h77, 5'd4, 1'b1); #1;
    checks++; if ({stallreq_mem, bus.dbus_req, wb_wreg, wb_wdata} !== {3'b001, 32'h0}) begin errors++;
      $display("FAIL sc_clr: got stall=%b req=%b wreg=%b wdata=%h expected 0 0 1 0", stallreq_mem, bus.dbus_req, wb_wreg, wb_wdata); end
    @(negedge clk); drive(EXE_ADDU_OP, 32'h0, 32'h0, 32'h5, 5'd3, 1'b1); #1;
    checks++; if (bus.dbus_req !== 1'b0) begin errors++;
      $display("FAIL sc_clr_bus: got req=%b expected 0", bus.dbus_req); end
    // Clear arriving with the LL ack wins
    @(negedge clk); drive(EXE_LL_OP, 32'h0000_0100, 32'h0, 32'h100, 5'd9, 1'b1); #1;
    @(negedge clk); bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h5; llbit_clr = 1'b1; #1;
    @(negedge clk); bus.dbus_ack = 1'b0; llbit_clr = 1'b0; #1;
    @(negedge clk); drive(EXE_SC_OP, 32'h0000_0100, 32'hDEAD_BEEF, 32'h77, 5'd4, 1'b1); #1;
    checks++; if ({stallreq_mem, bus.dbus_req, wb_wreg, wb_wdata} !== {3'b001, 32'h0}) begin errors++;
      $display("FAIL sc_clr_wins: got stall=%b req=%b wreg=%b wdata=%h expected 0 0 1 0", stallreq_mem, bus.dbus_req, wb_wreg, wb_wdata); end
  endtask
`else
  task automatic test_llsc();
    run_load(EXE_LL_OP, 32'h0000_0100, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344, "ll");
    run_store(EXE_SC_OP, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h1, "sc");
  endtask
`endif

  initial begin
`ifdef MEM_LLSC_EN
    llbit_clr = 1'b0;
`endif
    test_reset();
    test_passthru();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_llsc();
    test_reset_in_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
